// File: rtl/add64_sched.sv
// add64_sched: two-client scheduler that runs 64-bit add/subtract on one
// shared 32-bit adder in two passes (low word, then high word), with the
// inter-pass carry held in a flop. Round-robin arbitration between clients.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req0/req1          client requests, held until matching gnt
//   a0,b0,sub0         client 0 operands and op (1 = a - b)
//   a1,b1,sub1         client 1 operands and op
//   gnt0/gnt1          one-cycle pulse: request accepted, operands latched
//   busy               operation in flight (state != IDLE)
//   done               one-cycle pulse: result/cout/ovf/done_id valid
//   done_id            client index of the completed operation
//   result, cout, ovf  64-bit result, carry out of bit 63, signed overflow

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module add64_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] a0,
  input  logic [63:0] b0,
  input  logic        sub0,
  input  logic [63:0] a1,
  input  logic [63:0] b1,
  input  logic        sub1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [63:0] result,
  output logic        cout,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} st_t;

  st_t         state, nxt;
  logic [63:0] a_r, b_r;     // b_r already inverted for subtract
  logic        sub_r, id_r, last, carry;
  logic [31:0] lo_r;
  logic        any_req, pick;
  logic [31:0] add_a, add_b, add_s;
  logic        add_cin, add_co;

  // Tie goes to the client not granted last; a lone requester always wins.
  assign any_req = req0 | req1;
  assign pick    = (req0 & req1) ? ~last : req1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = LOW;
      LOW:     nxt = HIGH;
      HIGH:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Shared adder input mux. IDLE selects the low word of the latched
  // operands; those registers are reset, so nothing downstream sees X.
  always_comb begin
    add_a   = a_r[31:0];
    add_b   = b_r[31:0];
    add_cin = sub_r;
    if (state == HIGH) begin
      add_a   = a_r[63:32];
      add_b   = b_r[63:32];
      add_cin = carry;
    end
  end

  add32 u_add (.a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_co));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      id_r    <= 1'b0;
      last    <= 1'b1;
      carry   <= 1'b0;
      lo_r    <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          a_r   <= pick ? a1 : a0;
          b_r   <= pick ? (sub1 ? ~b1 : b1) : (sub0 ? ~b0 : b0);
          sub_r <= pick ? sub1 : sub0;
          id_r  <= pick;
          last  <= pick;
          gnt0  <= ~pick;
          gnt1  <= pick;
        end
        LOW: begin
          lo_r  <= add_s;
          carry <= add_co;
        end
        HIGH: begin
          result  <= {add_s, lo_r};
          cout    <= add_co;
          ovf     <= (a_r[63] == b_r[63]) && (add_s[31] != a_r[63]);
          done_id <= id_r;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_add64_sched.sv
module tb_add64_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, sub0, sub1;
  logic [63:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id, cout, ovf;
  logic [63:0] result;

  add64_sched dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .sub0(sub0),
    .a1(a1), .b1(b1), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic        sub;
    int          gap;
    bit          abandon;
  } cmd_t;

  typedef struct {
    logic [63:0] r;
    logic        c, o, id;
    int          gcyc;
  } exp_t;

  cmd_t cq0[$], cq1[$];
  exp_t sbq[$];
  int   gord[$], gcy[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   act[2], gapc[2], wt[2];
  cmd_t cur[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain 64-bit arithmetic and signed-overflow rules.
  function automatic exp_t model(input logic [63:0] a, b, input logic sub, input logic id, input int gc);
    exp_t e;
    logic [64:0] s;
    if (sub) begin
      s   = {1'b0, a} - {1'b0, b};
      e.c = (a >= b);
      e.o = (a[63] != b[63]) && (s[63] != a[63]);
    end else begin
      s   = {1'b0, a} + {1'b0, b};
      e.c = s[64];
      e.o = (a[63] == b[63]) && (s[63] != a[63]);
    end
    e.r = s[63:0]; e.id = id; e.gcyc = gc;
    return e;
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0: v = 64'hFFFF_FFFF_FFFF_FFFF;
      1: v = 64'h7FFF_FFFF_FFFF_FFFF;
      2: v = {32'd0, $urandom()};
      3: v = {$urandom(), 32'hFFFF_FFFF};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic bit gnt_of(input int c);
    return (c == 0) ? gnt0 : gnt1;
  endfunction

  function automatic int qsize(input int c);
    return (c == 0) ? cq0.size() : cq1.size();
  endfunction

  function automatic cmd_t qpop(input int c);
    return (c == 0) ? cq0.pop_front() : cq1.pop_front();
  endfunction

  task automatic set_client(input int c, input logic r, input logic [63:0] a, b, input logic s);
    if (c == 0) begin req0 = r; a0 = a; b0 = b; sub0 = s; end
    else        begin req1 = r; a1 = a; b1 = b; sub1 = s; end
  endtask

  // Single driver process for both clients: holds req until gnt, then
  // scrambles the operands so the DUT must rely on its latched copy.
  initial begin
    for (int c = 0; c < 2; c++) begin
      act[c] = 0; gapc[c] = 0; wt[c] = 0;
      set_client(c, 1'b0, 64'd0, 64'd0, 1'b0);
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (act[c] == 2) begin
          if (gnt_of(c)) begin
            gord.push_back(c);
            gcy.push_back(cyc);
            if (!cur[c].abandon)
              sbq.push_back(model(cur[c].a, cur[c].b, cur[c].sub, c[0], cyc));
            set_client(c, 1'b0, rand64(), rand64(), $urandom_range(0, 1) == 1);
            act[c] = 0;
          end else if (++wt[c] > 60) begin
            errors++;
            $display("FAIL gnt_timeout: client %0d got no gnt expected one within 60 cycles", c);
            set_client(c, 1'b0, 64'd0, 64'd0, 1'b0);
            act[c] = 0;
          end
        end
        if (act[c] == 1) begin
          if (--gapc[c] <= 0) begin
            set_client(c, 1'b1, cur[c].a, cur[c].b, cur[c].sub);
            act[c] = 2; wt[c] = 0;
          end
        end else if (act[c] == 0 && qsize(c) > 0) begin
          cur[c] = qpop(c);
          if (cur[c].gap == 0) begin
            set_client(c, 1'b1, cur[c].a, cur[c].b, cur[c].sub);
            act[c] = 2; wt[c] = 0;
          end else begin
            gapc[c] = cur[c].gap;
            act[c]  = 1;
          end
        end
      end
    end
  end

  // Monitor: every done pops one expectation and checks value and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: got done=1 expected no pending operation");
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.r);
          chk("cout", {63'd0, cout}, {63'd0, e.c});
          chk("ovf", {63'd0, ovf}, {63'd0, e.o});
          chk("done_id", {63'd0, done_id}, {63'd0, e.id});
          chk("latency", 64'(cyc - e.gcyc), 64'd2);
          chk("gnt_with_done", {62'd0, gnt1, gnt0}, 64'd0);
        end
      end
      if (gnt0 && gnt1) begin
        checks++; errors++;
        $display("FAIL dual_gnt: got gnt0=1 gnt1=1 expected at most one");
      end
    end
  end

  task automatic push_cmd(input int c, input logic [63:0] a, b, input logic sub, input int gap, input bit ab);
    cmd_t k;
    k.a = a; k.b = b; k.sub = sub; k.gap = gap; k.abandon = ab;
    if (c == 0) cq0.push_back(k); else cq1.push_back(k);
  endtask

  task automatic drain();
    int n = 0;
    while ((cq0.size() || cq1.size() || act[0] || act[1] || sbq.size()) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {58'd0, gnt0, gnt1, busy, done, cout, ovf}, 64'd0);
    chk("rst_done_id", {63'd0, done_id}, 64'd0);
    reset = 1'b0;

    // Directed corner cases
    push_cmd(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0, 0);
    push_cmd(1, 64'd5, 64'd7, 1'b1, 1, 0);
    push_cmd(1, 64'd7, 64'd5, 1'b1, 0, 0);
    push_cmd(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4, 0);
    push_cmd(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 0);
    push_cmd(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0, 0);
    drain();

    // Reset during the LOW pass: abandoned, no done may follow
    push_cmd(0, 64'h1234, 64'h5678, 1'b0, 0, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 20);
    chk("abandon_gnt", {63'd0, gnt0}, 64'd1);
    chk("abandon_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_result", result, 64'd0);
    chk("midrst_flags", {57'd0, done_id, gnt0, gnt1, busy, done, cout, ovf}, 64'd0);
    repeat (6) @(negedge clk);

    // Fairness: both held continuously after reset -> 0,1,0,1 every 3 cycles
    gord.delete(); gcy.delete();
    push_cmd(0, 64'h1111_0000_2222_0000, 64'h0000_3333_0000_4444, 1'b0, 0, 0);
    push_cmd(1, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b1, 0, 0);
    push_cmd(0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b1, 0, 0);
    push_cmd(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 0);
    drain();
    chk("fair_count", 64'(gord.size()), 64'd4);
    if (gord.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("fair_order", 64'(gord[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk("fair_spacing", 64'(gcy[i] - gcy[i-1]), 64'd3);
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      push_cmd(0, rand64(), rand64(), $urandom_range(0, 1) == 1, $urandom_range(0, 4), 0);
      push_cmd(1, rand64(), rand64(), $urandom_range(0, 1) == 1, $urandom_range(0, 4), 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
